// File: rtl/iopmp_checker_pipe.sv
// iopmp_checker_pipe: pipelined IOPMP checker.
// Source ID -> domain mask (SRCMD), TOR-style entries grouped per domain,
// two-stage valid/ready pipeline, first-violation capture, saturating count, irq.

// Single-entry hit test: enabled, in [base, limit), owning domain granted, perm ok.
module iopmp_entry_match #(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] base,
   input  logic [ADDR_W-1:0] limit,
   input  logic [2:0]        perm,
   input  logic              dom_en,
   input  logic [ADDR_W-1:0] addr,
   input  logic              write,
   output logic              hit
);
   // base >= limit yields an empty range, so it never hits without a special case
   assign hit = perm[2] & dom_en & (addr >= base) & (addr < limit) &
                (write ? perm[1] : perm[0]);
endmodule

module iopmp_checker_pipe #(
   parameter int NUM_SRC      = 8,
   parameter int NUM_MD       = 4,
   parameter int ENT_PER_MD   = 4,
   parameter int ADDR_W       = 32,
   parameter int TRUSTED_SRC0 = 1,
   localparam int SW          = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   localparam int NE          = NUM_MD * ENT_PER_MD
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [SW-1:0]     req_src,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_write,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_deny,
   input  logic              cfg_wen,
   input  logic              cfg_ren,
   input  logic [11:0]       cfg_addr,
   input  logic [31:0]       cfg_wdata,
   output logic [31:0]       cfg_rdata,
   input  logic              err_clr,
   output logic              err_valid,
   output logic [SW-1:0]     err_src,
   output logic [ADDR_W-1:0] err_addr,
   output logic              err_write,
   output logic [7:0]        err_cnt,
   output logic              irq
);

   localparam int STAGES = 2;

   typedef struct packed {
      logic [SW-1:0]     src;
      logic [ADDR_W-1:0] addr;
      logic              write;
   } req_t;

   // configuration tables
   logic [NUM_SRC-1:0][NUM_MD-1:0] srcmd_mask;
   logic [NUM_SRC-1:0]             srcmd_lock;
   logic [NE-1:0][ADDR_W-1:0]      ent_base;
   logic [NE-1:0][ADDR_W-1:0]      ent_limit;
   logic [NE-1:0][2:0]             ent_perm;

   logic [1:0]  cfg_sel;
   logic [7:0]  cfg_idx;
   logic [31:0] rd_data;

   // pipeline
   logic [STAGES:1]   vld_pipe;
   req_t              s1_req;
   req_t              err_rec;
   logic              stall;
   logic              s1_deny;
   logic              load_deny;
   logic              trusted;
   logic              src_oob;
   logic [NUM_MD-1:0] md_mask;
   logic [NE-1:0]     ent_hit;

   assign cfg_sel = cfg_addr[11:10];
   assign cfg_idx = cfg_addr[7:0];

   // table writes; out-of-range indices and locked SRCMD rows are ignored
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         srcmd_mask <= '0;
         srcmd_lock <= '0;
         ent_base   <= '0;
         ent_limit  <= '0;
         ent_perm   <= '0;
      end else if (cfg_wen) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (cfg_sel == 2'b00 && 32'(cfg_idx) == 32'(i) && !srcmd_lock[i]) begin
               srcmd_mask[i] <= cfg_wdata[NUM_MD-1:0];
               srcmd_lock[i] <= cfg_wdata[31];
            end
         end
         for (int i = 0; i < NE; i++) begin
            if (32'(cfg_idx) == 32'(i)) begin
               case (cfg_sel)
                  2'b01:   ent_base[i]  <= cfg_wdata[ADDR_W-1:0];
                  2'b10:   ent_limit[i] <= cfg_wdata[ADDR_W-1:0];
                  2'b11:   ent_perm[i]  <= cfg_wdata[2:0];
                  default: ;
               endcase
            end
         end
      end
   end

   // read mux over current table state (same-cycle write not yet visible)
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (cfg_sel == 2'b00 && 32'(cfg_idx) == 32'(i))
            rd_data = 32'(srcmd_mask[i]) | {srcmd_lock[i], 31'b0};
      end
      for (int i = 0; i < NE; i++) begin
         if (32'(cfg_idx) == 32'(i)) begin
            case (cfg_sel)
               2'b01:   rd_data = 32'(ent_base[i]);
               2'b10:   rd_data = 32'(ent_limit[i]);
               2'b11:   rd_data = 32'(ent_perm[i]);
               default: ;
            endcase
         end
      end
   end

   // registered config read, held until the next read strobe
   always_ff @(posedge clk) begin
      if (!rst_n)       cfg_rdata <= '0;
      else if (cfg_ren) cfg_rdata <= rd_data;
   end

   // domain mask of the S1 source; unknown sources get no domains
   always_comb begin
      md_mask = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (32'(s1_req.src) == 32'(i)) md_mask = srcmd_mask[i];
      end
   end

   for (genvar e = 0; e < NE; e++) begin : g_ent
      iopmp_entry_match #(.ADDR_W(ADDR_W)) u_match (
         .base   (ent_base[e]),
         .limit  (ent_limit[e]),
         .perm   (ent_perm[e]),
         .dom_en (md_mask[e / ENT_PER_MD]),
         .addr   (s1_req.addr),
         .write  (s1_req.write),
         .hit    (ent_hit[e])
      );
   end

   assign trusted = (TRUSTED_SRC0 != 0) && (s1_req.src == '0);
   assign src_oob = 32'(s1_req.src) >= 32'(NUM_SRC);
   assign s1_deny = trusted ? 1'b0 : (src_oob | ~|ent_hit);

   assign stall      = vld_pipe[STAGES] & ~resp_ready;
   assign req_ready  = ~stall;
   assign resp_valid = vld_pipe[STAGES];
   assign load_deny  = ~stall & vld_pipe[1] & s1_deny;

   // S1/S2 advance together; both freeze while the response is back-pressured
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe  <= '0;
         s1_req    <= '0;
         resp_deny <= 1'b0;
      end else if (!stall) begin
         vld_pipe  <= {vld_pipe[STAGES-1:1], req_valid};
         resp_deny <= vld_pipe[1] & s1_deny;
         if (req_valid)
            s1_req <= '{src: req_src, addr: req_addr, write: req_write};
      end
   end

   // error record and count: clear first, then capture a deny loading into S2
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_valid <= 1'b0;
         err_cnt   <= '0;
         err_rec   <= '0;
      end else if (load_deny) begin
         if (err_clr)                err_cnt <= 8'd1;
         else if (err_cnt != 8'hFF)  err_cnt <= err_cnt + 8'd1;
         if (err_clr || !err_valid) begin
            err_valid <= 1'b1;
            err_rec   <= s1_req;
         end
      end else if (err_clr) begin
         err_valid <= 1'b0;
         err_cnt   <= '0;
      end
   end

   assign err_src   = err_rec.src;
   assign err_addr  = err_rec.addr;
   assign err_write = err_rec.write;
   assign irq       = err_valid;

endmodule
